// File: rtl/id_ex_hazard_reg_pkg.sv
// Shared pipeline definitions for the decode/execute boundary.
// Holds width defaults, the immediate-extend encoding and the control bundle
// that travels from stage 2 to stage 3.
package id_ex_hazard_reg_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 4;
    localparam int CNT_W_DEF  = 16;

    // Immediate-extend select encoding (consumed by the execute stage).
    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_HIGH = 2'b10;
    localparam logic [1:0] EXT_RSVD = 2'b11;

    // Control bundle carried alongside the operands.
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic       imm_f;
        logic [1:0] extnd_sel;
    } ctrl_t;

    // A bubble keeps the decoded shape but can neither write back nor load.
    function automatic ctrl_t make_bubble(input ctrl_t c);
        ctrl_t b;
        b           = c;
        b.valid     = 1'b0;
        b.reg_write = 1'b0;
        b.mem_read  = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/id_ex_hazard_reg_if.sv
// Bundle of decode-side inputs and execute-side outputs of the ID/EX register.
// master = decode/execute environment, slave = the pipeline register itself.
interface id_ex_hazard_reg_if
    import id_ex_hazard_reg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    // Stage-2 (decode) side
    logic [DATA_W-1:0] R2res2;
    logic [DATA_W-1:0] R3res2;
    logic [REG_W-1:0]  R2_2;
    logic [REG_W-1:0]  R3_2;
    logic [REG_W-1:0]  DestR_2;
    logic [1:0]        ExtndSel2;
    logic              immF2;
    logic              RegWrite2;
    logic              MemRead2;
    logic              valid2;
    logic              flush;
    logic              mem_busy;

    // Stage-3 (execute) side
    logic [DATA_W-1:0] R2res3;
    logic [DATA_W-1:0] R3res3;
    logic [REG_W-1:0]  R2_3;
    logic [REG_W-1:0]  R3_3;
    logic [REG_W-1:0]  DestR_3;
    logic [1:0]        ExtndSel3;
    logic              immF3;
    logic              RegWrite3;
    logic              MemRead3;
    logic              valid3;
    logic              stall;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output R2res2, R3res2, R2_2, R3_2, DestR_2, ExtndSel2, immF2,
               RegWrite2, MemRead2, valid2, flush, mem_busy,
        input  R2res3, R3res3, R2_3, R3_3, DestR_3, ExtndSel3, immF3,
               RegWrite3, MemRead3, valid3, stall, stall_cnt
    );

    modport slave (
        input  R2res2, R3res2, R2_2, R3_2, DestR_2, ExtndSel2, immF2,
               RegWrite2, MemRead2, valid2, flush, mem_busy,
        output R2res3, R3res3, R2_3, R3_3, DestR_3, ExtndSel3, immF3,
               RegWrite3, MemRead3, valid3, stall, stall_cnt
    );

endinterface

// File: rtl/id_ex_hazard_reg_load_use_detect.sv
// Load-use hazard detector: flags a decode instruction that reads the
// destination of a load currently in execute. Purely combinational.
// The R3 source is ignored when the immediate replaces it.
module load_use_detect #(
    parameter int REG_W = 4
) (
    input  logic             i_valid3,
    input  logic             i_mem_read3,
    input  logic [REG_W-1:0] i_dest_r3,
    input  logic             i_valid2,
    input  logic             i_imm_f2,
    input  logic [REG_W-1:0] i_r2_2,
    input  logic [REG_W-1:0] i_r3_2,
    output logic             o_hazard
);

    logic w_r2_match;
    logic w_r3_match;

    // Compare the load destination against each live decode source.
    always_comb begin
        w_r2_match = (i_dest_r3 == i_r2_2);
        w_r3_match = (~i_imm_f2) & (i_dest_r3 == i_r3_2);
        o_hazard   = i_valid3 & i_mem_read3 & i_valid2 & (w_r2_match | w_r3_match);
    end

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use stall.
// Priority each cycle: memory freeze, then branch flush, then load-use bubble,
// then a normal capture. stall is combinational so fetch/decode hold in the
// same cycle the hazard is seen.
module id_ex_hazard_reg
    import id_ex_hazard_reg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    id_ex_hazard_reg_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Stage-3 state
    logic [DATA_W-1:0] r_r2res;
    logic [DATA_W-1:0] r_r3res;
    logic [REG_W-1:0]  r_r2;
    logic [REG_W-1:0]  r_r3;
    logic [REG_W-1:0]  r_dest;
    ctrl_t             r_ctrl3;
    logic [CNT_W-1:0]  r_stall_cnt;

    // Next-state signals
    ctrl_t             w_ctrl2;
    ctrl_t             w_ctrl3_nxt;
    logic              w_load;
    logic              w_stall;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_hazard;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use_detect (
        .i_valid3    (r_ctrl3.valid),
        .i_mem_read3 (r_ctrl3.mem_read),
        .i_dest_r3   (r_dest),
        .i_valid2    (bus.valid2),
        .i_imm_f2    (bus.immF2),
        .i_r2_2      (bus.R2_2),
        .i_r3_2      (bus.R3_2),
        .o_hazard    (w_hazard)
    );

    // Priority mux: decides hold / bubble / capture, stall and counter update.
    always_comb begin
        w_ctrl2.valid     = bus.valid2;
        w_ctrl2.reg_write = bus.RegWrite2;
        w_ctrl2.mem_read  = bus.MemRead2;
        w_ctrl2.imm_f     = bus.immF2;
        w_ctrl2.extnd_sel = bus.ExtndSel2;

        w_load      = 1'b0;
        w_stall     = 1'b0;
        w_ctrl3_nxt = r_ctrl3;
        w_cnt_nxt   = r_stall_cnt;

        if (bus.mem_busy) begin
            // Freeze: everything holds, upstream must hold too.
            w_stall = 1'b1;
        end else if (bus.flush) begin
            // Killed instruction enters as a bubble and is not counted.
            w_load      = 1'b1;
            w_ctrl3_nxt = make_bubble(w_ctrl2);
        end else if (w_hazard) begin
            // Load-use: insert one bubble, decode replays next cycle.
            w_load      = 1'b1;
            w_stall     = 1'b1;
            w_ctrl3_nxt = make_bubble(w_ctrl2);
            if (r_stall_cnt != CNT_MAX) begin
                w_cnt_nxt = r_stall_cnt + CNT_ONE;
            end else begin
                w_cnt_nxt = r_stall_cnt;
            end
        end else begin
            w_load      = 1'b1;
            w_ctrl3_nxt = w_ctrl2;
        end
    end

    // Stage-3 register bank and stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r2res     <= {DATA_W{1'b0}};
            r_r3res     <= {DATA_W{1'b0}};
            r_r2        <= {REG_W{1'b0}};
            r_r3        <= {REG_W{1'b0}};
            r_dest      <= {REG_W{1'b0}};
            r_ctrl3     <= '0;
            r_stall_cnt <= {CNT_W{1'b0}};
        end else begin
            r_ctrl3     <= w_ctrl3_nxt;
            r_stall_cnt <= w_cnt_nxt;
            if (w_load) begin
                r_r2res <= bus.R2res2;
                r_r3res <= bus.R3res2;
                r_r2    <= bus.R2_2;
                r_r3    <= bus.R3_2;
                r_dest  <= bus.DestR_2;
            end else begin
                r_r2res <= r_r2res;
                r_r3res <= r_r3res;
                r_r2    <= r_r2;
                r_r3    <= r_r3;
                r_dest  <= r_dest;
            end
        end
    end

    assign bus.R2res3    = r_r2res;
    assign bus.R3res3    = r_r3res;
    assign bus.R2_3      = r_r2;
    assign bus.R3_3      = r_r3;
    assign bus.DestR_3   = r_dest;
    assign bus.ExtndSel3 = r_ctrl3.extnd_sel;
    assign bus.immF3     = r_ctrl3.imm_f;
    assign bus.RegWrite3 = r_ctrl3.reg_write;
    assign bus.MemRead3  = r_ctrl3.mem_read;
    assign bus.valid3    = r_ctrl3.valid;
    assign bus.stall     = w_stall;
    assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed bench for id_ex_hazard_reg (CNT_W = 4 build so saturation is reachable).
module tb_id_ex_hazard_reg;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cur_row;
    logic [3:0] exp_cnt;

    id_ex_hazard_reg_if #(.DATA_W(32), .REG_W(4), .CNT_W(4)) bus ();

    id_ex_hazard_reg #(.DATA_W(32), .REG_W(4), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v2, rd2, imm2, fl, busy;
        logic [1:0]  ext2;
        logic [3:0]  r2, r3, dst;
        logic [31:0] a;
        logic        e_stall, e_v3, e_rd3, e_wr3, dchk, e_imm3;
        logic [3:0]  e_dst3, e_r2_3, e_r3_3, e_cnt;
        logic [31:0] e_a3;
        logic [1:0]  e_ext3;
    } vec_t;

    localparam int NV = 17;
    vec_t tv [NV];

    function automatic vec_t mk(
        input logic v2, input logic rd2, input logic imm2, input logic [1:0] ext2,
        input logic [3:0] r2, input logic [3:0] r3, input logic [3:0] dst,
        input logic [31:0] a, input logic fl, input logic busy,
        input logic e_stall, input logic e_v3, input logic e_rd3, input logic e_wr3,
        input logic dchk, input logic [3:0] e_dst3, input logic [3:0] e_r2_3,
        input logic [3:0] e_r3_3, input logic [31:0] e_a3, input logic e_imm3,
        input logic [1:0] e_ext3, input logic [3:0] e_cnt);
        vec_t v;
        v.v2 = v2; v.rd2 = rd2; v.imm2 = imm2; v.ext2 = ext2;
        v.r2 = r2; v.r3 = r3; v.dst = dst; v.a = a; v.fl = fl; v.busy = busy;
        v.e_stall = e_stall; v.e_v3 = e_v3; v.e_rd3 = e_rd3; v.e_wr3 = e_wr3;
        v.dchk = dchk; v.e_dst3 = e_dst3; v.e_r2_3 = e_r2_3; v.e_r3_3 = e_r3_3;
        v.e_a3 = e_a3; v.e_imm3 = e_imm3; v.e_ext3 = e_ext3; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (row/step %0d): got %0h expected %0h", name, cur_row, act, exp);
        end
    endtask

    // R3 operand is derived from R2 operand so both can be checked from one column.
    task automatic drive(input logic v2, input logic rd2, input logic imm2, input logic [1:0] ext2,
                         input logic [3:0] r2, input logic [3:0] r3, input logic [3:0] dst,
                         input logic [31:0] a, input logic fl, input logic busy);
        bus.valid2    = v2;
        bus.MemRead2  = rd2;
        bus.RegWrite2 = 1'b1;
        bus.immF2     = imm2;
        bus.ExtndSel2 = ext2;
        bus.R2_2      = r2;
        bus.R3_2      = r3;
        bus.DestR_2   = dst;
        bus.R2res2    = a;
        bus.R3res2    = a + 32'h554;
        bus.flush     = fl;
        bus.mem_busy  = busy;
    endtask

    task automatic chk_reset_state();
        chk("rst_stall",    {31'd0, bus.stall},     32'd0);
        chk("rst_valid3",   {31'd0, bus.valid3},    32'd0);
        chk("rst_memread3", {31'd0, bus.MemRead3},  32'd0);
        chk("rst_regwr3",   {31'd0, bus.RegWrite3}, 32'd0);
        chk("rst_immf3",    {31'd0, bus.immF3},     32'd0);
        chk("rst_ext3",     {30'd0, bus.ExtndSel3}, 32'd0);
        chk("rst_dest3",    {28'd0, bus.DestR_3},   32'd0);
        chk("rst_r2_3",     {28'd0, bus.R2_3},      32'd0);
        chk("rst_r3_3",     {28'd0, bus.R3_3},      32'd0);
        chk("rst_r2res3",   bus.R2res3,             32'd0);
        chk("rst_r3res3",   bus.R3res3,             32'd0);
        chk("rst_cnt",      {28'd0, bus.stall_cnt}, 32'd0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cur_row = 0;

        //          v2    rd2   imm2  ext2   r2    r3    dst    a        fl    busy | stall v3   rd3   wr3   dchk  dst3   r2_3  r3_3  a3       imm3  ext3   cnt
        tv[0]  = mk(1'b1, 1'b0, 1'b0, 2'd0, 4'd5, 4'd0, 4'd7,  32'h10,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd7,  4'd5, 4'd0, 32'h10,  1'b0, 2'd0, 4'd0);
        tv[1]  = mk(1'b1, 1'b1, 1'b0, 2'd0, 4'd1, 4'd2, 4'd5,  32'h20,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd5,  4'd1, 4'd2, 32'h20,  1'b0, 2'd0, 4'd0);
        tv[2]  = mk(1'b1, 1'b0, 1'b0, 2'd0, 4'd5, 4'd3, 4'd8,  32'h40,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0, 4'd0, 32'h0,   1'b0, 2'd0, 4'd1);
        tv[3]  = mk(1'b1, 1'b0, 1'b0, 2'd0, 4'd5, 4'd3, 4'd8,  32'h40,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd8,  4'd5, 4'd3, 32'h40,  1'b0, 2'd0, 4'd1);
        tv[4]  = mk(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 4'd6,  32'h50,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd6,  4'd0, 4'd0, 32'h50,  1'b0, 2'd0, 4'd1);
        tv[5]  = mk(1'b1, 1'b0, 1'b1, 2'd2, 4'd1, 4'd6, 4'd9,  32'h60,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd9,  4'd1, 4'd6, 32'h60,  1'b1, 2'd2, 4'd1);
        tv[6]  = mk(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 4'd6,  32'h70,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd6,  4'd0, 4'd0, 32'h70,  1'b0, 2'd0, 4'd1);
        tv[7]  = mk(1'b1, 1'b0, 1'b0, 2'd0, 4'd1, 4'd6, 4'd9,  32'h80,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0, 4'd0, 32'h0,   1'b0, 2'd0, 4'd2);
        tv[8]  = mk(1'b1, 1'b0, 1'b0, 2'd0, 4'd1, 4'd6, 4'd9,  32'h80,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd9,  4'd1, 4'd6, 32'h80,  1'b0, 2'd0, 4'd2);
        tv[9]  = mk(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 4'd4,  32'h90,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd4,  4'd0, 4'd0, 32'h90,  1'b0, 2'd0, 4'd2);
        tv[10] = mk(1'b1, 1'b0, 1'b0, 2'd0, 4'd4, 4'd0, 4'd10, 32'hA0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0, 4'd0, 32'h0,   1'b0, 2'd0, 4'd2);
        tv[11] = mk(1'b1, 1'b0, 1'b0, 2'd0, 4'd4, 4'd0, 4'd3,  32'hB0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3,  4'd4, 4'd0, 32'hB0,  1'b0, 2'd0, 4'd2);
        tv[12] = mk(1'b1, 1'b0, 1'b0, 2'd0, 4'd3, 4'd0, 4'd12, 32'hC0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd12, 4'd3, 4'd0, 32'hC0,  1'b0, 2'd0, 4'd2);
        tv[13] = mk(1'b1, 1'b1, 1'b0, 2'd0, 4'd1, 4'd1, 4'd0,  32'hD0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  4'd1, 4'd1, 32'hD0,  1'b0, 2'd0, 4'd2);
        tv[14] = mk(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 4'd5, 4'd11, 32'hE0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0, 4'd0, 32'h0,   1'b0, 2'd0, 4'd3);
        tv[15] = mk(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 4'd2,  32'hF0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd2,  4'd0, 4'd0, 32'hF0,  1'b0, 2'd0, 4'd3);
        tv[16] = mk(1'b0, 1'b0, 1'b0, 2'd0, 4'd2, 4'd0, 4'd13, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 4'd2, 4'd0, 32'h100, 1'b0, 2'd0, 4'd3);

        // Reset state
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 4'd0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state();
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            cur_row = i;
            drive(tv[i].v2, tv[i].rd2, tv[i].imm2, tv[i].ext2, tv[i].r2, tv[i].r3,
                  tv[i].dst, tv[i].a, tv[i].fl, tv[i].busy);
            #1;
            chk("stall", {31'd0, bus.stall}, {31'd0, tv[i].e_stall});
            @(posedge clk);
            #1;
            chk("valid3",    {31'd0, bus.valid3},    {31'd0, tv[i].e_v3});
            chk("memread3",  {31'd0, bus.MemRead3},  {31'd0, tv[i].e_rd3});
            chk("regwrite3", {31'd0, bus.RegWrite3}, {31'd0, tv[i].e_wr3});
            chk("stall_cnt", {28'd0, bus.stall_cnt}, {28'd0, tv[i].e_cnt});
            if (tv[i].dchk) begin
                chk("dest3",  {28'd0, bus.DestR_3},   {28'd0, tv[i].e_dst3});
                chk("r2_3",   {28'd0, bus.R2_3},      {28'd0, tv[i].e_r2_3});
                chk("r3_3",   {28'd0, bus.R3_3},      {28'd0, tv[i].e_r3_3});
                chk("r2res3", bus.R2res3,             tv[i].e_a3);
                chk("r3res3", bus.R3res3,             tv[i].e_a3 + 32'h554);
                chk("immf3",  {31'd0, bus.immF3},     {31'd0, tv[i].e_imm3});
                chk("ext3",   {30'd0, bus.ExtndSel3}, {30'd0, tv[i].e_ext3});
            end
        end

        // Freeze: load in execute, decode changes under mem_busy (flush on last cycle)
        cur_row = 100;
        drive(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 4'd7, 32'hAA, 1'b0, 1'b0);
        #1;
        chk("frz_pre_stall", {31'd0, bus.stall}, 32'd0);
        @(posedge clk);
        #1;
        chk("frz_pre_valid3", {31'd0, bus.valid3}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            cur_row = 101 + k;
            drive(1'b1, 1'b0, 1'b0, 2'd1, 4'd7, 4'(k), 4'(k + 1), 32'h100 + 32'(k),
                  (k == 2) ? 1'b1 : 1'b0, 1'b1);
            #1;
            chk("frz_stall", {31'd0, bus.stall}, 32'd1);
            @(posedge clk);
            #1;
            chk("frz_valid3",   {31'd0, bus.valid3},    32'd1);
            chk("frz_memread3", {31'd0, bus.MemRead3},  32'd1);
            chk("frz_dest3",    {28'd0, bus.DestR_3},   32'd7);
            chk("frz_r2_3",     {28'd0, bus.R2_3},      32'd0);
            chk("frz_r2res3",   bus.R2res3,             32'hAA);
            chk("frz_r3res3",   bus.R3res3,             32'hAA + 32'h554);
            chk("frz_ext3",     {30'd0, bus.ExtndSel3}, 32'd0);
            chk("frz_cnt",      {28'd0, bus.stall_cnt}, 32'd3);
        end

        // Freeze released: pending load-use now stalls once
        cur_row = 110;
        drive(1'b1, 1'b0, 1'b0, 2'd0, 4'd7, 4'd0, 4'd1, 32'h200, 1'b0, 1'b0);
        #1;
        chk("rel_stall", {31'd0, bus.stall}, 32'd1);
        @(posedge clk);
        #1;
        chk("rel_valid3", {31'd0, bus.valid3},    32'd0);
        chk("rel_cnt",    {28'd0, bus.stall_cnt}, 32'd4);
        #1;
        chk("rel_replay_stall", {31'd0, bus.stall}, 32'd0);
        @(posedge clk);
        #1;
        chk("rel_replay_valid3", {31'd0, bus.valid3}, 32'd1);
        chk("rel_replay_r2res3", bus.R2res3,          32'h200);

        // Saturation: repeated load-use pairs drive the 4-bit counter to 4'hF and beyond
        exp_cnt = 4'd4;
        for (int k = 0; k < 12; k++) begin
            cur_row = 200 + k;
            drive(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 4'd9, 32'h300, 1'b0, 1'b0);
            #1;
            chk("sat_load_stall", {31'd0, bus.stall}, 32'd0);
            @(posedge clk);
            #1;
            drive(1'b1, 1'b0, 1'b0, 2'd0, 4'd9, 4'd0, 4'd3, 32'h400, 1'b0, 1'b0);
            #1;
            chk("sat_use_stall", {31'd0, bus.stall}, 32'd1);
            @(posedge clk);
            if (exp_cnt != 4'hF) begin
                exp_cnt = exp_cnt + 4'd1;
            end else begin
                exp_cnt = exp_cnt;
            end
            #1;
            chk("sat_cnt",    {28'd0, bus.stall_cnt}, {28'd0, exp_cnt});
            chk("sat_valid3", {31'd0, bus.valid3},    32'd0);
        end
        chk("sat_final", {28'd0, bus.stall_cnt}, 32'hF);

        // Reset asserted mid-stall
        cur_row = 300;
        drive(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 4'd9, 32'h500, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, 2'd0, 4'd9, 4'd0, 4'd3, 32'h600, 1'b0, 1'b0);
        #1;
        chk("mid_stall", {31'd0, bus.stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_state();
        drive(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 4'd0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_valid3", {31'd0, bus.valid3},    32'd0);
        chk("post_rst_cnt",    {28'd0, bus.stall_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_reg.md
# id_ex_hazard_reg

Pipeline register between decode (stage 2) and execute (stage 3) with load-use hazard detection. It captures decoded operands, register indices and control from decode. It detects when the instruction in execute is a load whose destination feeds the instruction in decode, and then holds decode/fetch and inserts a bubble. Its stage-3 outputs feed the ALU forwarding unit directly (operand values, source indices, ExtndSel, immF).

## Interface
- DATA_W, 32, operand width
- REG_W, 4, register index width (16 registers, all compared; no hardwired zero register)
- CNT_W, 16, width of the stall-cycle counter
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- R2res2, R3res2  in  DATA_W  operand values read in decode
- R2_2, R3_2, DestR_2  in  REG_W  source/destination indices in decode
- ExtndSel2  in  2  immediate-extend select; immF2  in  1  immediate replaces R3
- RegWrite2, MemRead2, valid2  in  1  decode control / valid
- flush  in  1  branch taken: kill the decode instruction
- mem_busy  in  1  memory stage not ready: freeze
- R2res3, R3res3  out  DATA_W  registered operands to execute
- R2_3, R3_3, DestR_3  out  REG_W  registered indices
- ExtndSel3  out  2; immF3, RegWrite3, MemRead3, valid3  out  1
- stall  out  1  combinational: hold PC and IF/ID register
- stall_cnt  out  CNT_W  saturating count of load-use bubble cycles

## Operation
- hazard = valid3 & MemRead3 & valid2 & ((DestR_3 == R2_2) | (~immF2 & DestR_3 == R3_2)).
- Priority each cycle, highest first:
  - mem_busy: all registers hold; stall = 1; counter holds.
  - flush: load bubble (valid3, RegWrite3, MemRead3 = 0; data/index fields may take decode values); stall = 0; counter holds.
  - hazard: load bubble; stall = 1; stall_cnt += 1, saturating at all-ones.
  - otherwise: load all decode fields; stall = 0.
- A bubble never causes a hazard in the next cycle because valid3 = 0, so a load-use stall lasts exactly one cycle.
- immF2 = 1 masks the R3 comparison. ExtndSel2 is not used in the hazard decision.
- There is no hazard on a non-load producer. The forwarding unit covers those.

## Timing
- Reset (async assert, synchronous release at next edge): all outputs 0, including valid3, stall_cnt and stall (stall is 0 because valid3 = 0).
- Latency: decode fields appear on stage-3 outputs one clk after capture.
- stall is combinational from the current stage-3 registers and the decode inputs. There is no registered delay.
- flush together with hazard: flush wins, stall = 0, and the killed instruction is not counted.
- mem_busy together with flush: freeze wins. The flush must be held by the producer until mem_busy drops.
- Reset asserted mid-stall: the bubble and the hold are discarded immediately. Outputs return to reset values.
- stall_cnt wraps never: it holds at 2^CNT_W-1.

## Structure
- A shared pipeline package holds DATA_W/REG_W defaults, the ExtndSel encoding constants, and a packed struct for the stage-2/3 control bundle (RegWrite, MemRead, immF, ExtndSel, valid).
- One sub-module, load_use_detect, is combinational and produces hazard. The top level holds the registers, the priority mux and the counter.

## Test plan
- Normal flow: valid2 = 1, R2res2 = 32'h10, R3res2 = 32'h564, R2_2 = 5, DestR_2 = 7 -> next cycle R2res3 = 32'h10, R3res3 = 32'h564, R2_3 = 5, DestR_3 = 7, valid3 = 1, stall = 0.
- Load-use on R2: stage 3 holds MemRead3 = 1, DestR_3 = 5, and decode has R2_2 = 5 -> stall = 1 for one cycle, then valid3 = 0, stall_cnt = 1; the following cycle the same decode instruction loads with stall = 0.
- Immediate mask: DestR_3 = 6 (load), R3_2 = 6, immF2 = 1, ExtndSel2 = 2'b10 -> stall = 0 and the instruction advances. With immF2 = 0 -> stall = 1.
- Flush against hazard: hazard conditions plus flush = 1 -> stall = 0, next valid3 = 0, stall_cnt unchanged.
- Freeze: mem_busy = 1 for 3 cycles with changing decode inputs -> all stage-3 outputs constant, stall = 1, counter constant.
- Reset and saturation: assert rst_n = 0 mid-stall -> all outputs 0 immediately. Preload the counter to all-ones (CNT_W = 4 build) and trigger a hazard -> stall_cnt stays 4'hF.
